rvb_pcpi_bridge: RTL and testbench
==================================

// Module: rvb_pcpi_bridge
// PURPOSE
//  Parametrised PCPI-to-worker bridge: connects the core's PCPI co-processor port to any bitmanip
//  worker with a valid/ready din/dout interface (e.g. rvb_full). Successor to the fixed 32-bit
//  wrapper: XLEN-generic, optional registered response, cancel/drain of abandoned operations,
//  watchdog timeout flag and completed-op counter. Worker instantiated outside; bridge is FSM-only.
// PARAMETERS
//  XLEN     32  operand/result width (32 or 64)
//  OUT_REG  1   1: result registered, pcpi_ready one cycle after w_dout_valid; 0: same cycle
//  TIMEOUT  64  cycles in WAIT before stat_timeout sets; 0 disables watchdog
//  CNT_W    32  width of stat_ops counter
// PORTS
//  clock          in   1      sole clock, all state on rising edge
//  reset          in   1      synchronous, active-high
//  pcpi_valid     in   1      core requests co-processor instruction
//  pcpi_insn      in   32     instruction word
//  pcpi_rs1/2/3   in   XLEN   operands
//  pcpi_wr        out  1      result write-back strobe (== pcpi_ready)
//  pcpi_rd        out  XLEN   result; 0 whenever pcpi_ready=0
//  pcpi_wait      out  1      instruction claimed, result pending
//  pcpi_ready     out  1      one-cycle result strobe
//  w_din_valid    out  1      issue to worker
//  w_din_ready    in   1      worker accepts issue
//  w_din_decoded  in   1      worker recognises w_din_insn (combinational from insn)
//  w_din_insn     out  32     = pcpi_insn (pass-through)
//  w_din_rs1/2/3  out  XLEN   = pcpi_rs1/2/3 (pass-through; worker latches on handshake)
//  w_dout_valid   in   1      worker result valid
//  w_dout_ready   out  1      bridge accepts result
//  w_dout_rd      in   XLEN   worker result
//  stat_timeout   out  1      sticky: watchdog expired since reset
//  stat_ops       out  CNT_W  completed (delivered) instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rd_q, wdog, stat_ops, stat_timeout cleared. Reset mid-op
//   aborts immediately, no pcpi_ready; worker shares the same reset.
//  States: IDLE, WAIT, RESP (OUT_REG=1 only), HOLD, DRAIN.
//  IDLE: w_din_valid = pcpi_valid & w_din_decoded. pcpi_wait = same. On w_din_valid&w_din_ready
//   -> WAIT, wdog<=0. Undecoded insn: no issue, pcpi_wait=0 (core traps), stay IDLE.
//  WAIT: w_dout_ready=1, pcpi_wait=pcpi_valid. wdog increments, saturates at TIMEOUT; on reaching
//   TIMEOUT (TIMEOUT!=0) stat_timeout<=1; op continues.
//   w_dout_valid & pcpi_valid: OUT_REG=0 -> pcpi_ready=pcpi_wr=1, pcpi_rd=w_dout_rd, stat_ops++,
//   -> HOLD. OUT_REG=1 -> rd_q<=w_dout_rd -> RESP.
//   pcpi_valid=0 (core abandoned op) without w_dout_valid -> DRAIN; with w_dout_valid -> result
//   discarded, -> HOLD, no pcpi_ready, stat_ops unchanged.
//  RESP: pcpi_ready=pcpi_wr=1, pcpi_rd=rd_q, pcpi_wait=0, stat_ops++ -> HOLD (even if
//   pcpi_valid dropped this cycle; core ignores stale ready).
//  HOLD: one cycle, no issue, pcpi_wait=0 (core drops pcpi_valid here) -> IDLE. Prevents
//   re-issuing the just-completed instruction.
//  DRAIN: w_dout_ready=1, result discarded; pcpi_wait=pcpi_valid&w_din_decoded (new insn stalls,
//   not issued); on w_dout_valid -> IDLE.
//  Never more than one op outstanding in worker. w_din_valid only ever asserted in IDLE.
//  Latency (worker result cycle W after issue): pcpi_ready at W (OUT_REG=0) or W+1 (OUT_REG=1).
// STRUCTURE
//  rvb_pcpi_pkg: state encoding localparams (ST_IDLE..ST_DRAIN), watchdog width function
//   ($clog2(TIMEOUT+1), min 1). Shared with future multi-worker bridges.
//  One natural sub-module: rvb_pcpi_wdog (saturating counter + sticky flag, params TIMEOUT).
//  Everything else flat in this module; no datapath beyond rd_q mux/gating.
// TESTING
//  1 XLEN=32,OUT_REG=1: insn decoded, worker ready at once, dout 3 cycles later rd=32'hDEADBEEF
//    -> pcpi_ready/wr one pulse 1 cycle after dout, pcpi_rd=DEADBEEF, stat_ops=1, no re-issue.
//  2 Undecoded insn, pcpi_valid held 10 cycles -> w_din_valid, pcpi_wait, pcpi_ready stay 0.
//  3 OUT_REG=0: dout valid with rd=5 -> pcpi_ready same cycle, pcpi_rd=5; next cycle pcpi_rd=0.
//  4 Drop pcpi_valid 2 cycles after issue, worker result 4 cycles later -> DRAIN, no pcpi_ready,
//    new pcpi_valid during DRAIN stalls with pcpi_wait=1, issues 1 cycle after drain completes.
//  5 TIMEOUT=8, worker answers after 12 cycles -> stat_timeout=1 from WAIT cycle 8, result still
//    delivered, stat_timeout stays 1 until reset.
//  6 XLEN=64: reset asserted in WAIT -> next cycle all outputs 0, state IDLE; fresh op completes
//    with 64-bit rd=64'h0123_4567_89AB_CDEF and stat_ops=1.

Source files
------------

// File: rtl/rvb_pcpi_pkg.sv
// Shared definitions for PCPI-to-worker bridges.
//  - Bridge FSM state encoding (ST_IDLE..ST_DRAIN) and the matching enum.
//  - wdog_w(): width of a watchdog counter that must be able to hold TIMEOUT.
package rvb_pcpi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_RESP  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP,
    S_HOLD  = ST_HOLD,
    S_DRAIN = ST_DRAIN
  } bridge_state_e;

  // Counter width able to hold 0..timeout; never narrower than one bit so a
  // disabled watchdog (timeout 0) still elaborates.
  function automatic int wdog_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rvb_pcpi_bridge_if.sv
// Bundle of the core-side PCPI port and the worker-side valid/ready port.
//  slave  : the bridge's view (accepts PCPI requests, issues to the worker)
//  master : the environment's view (core + worker)
//  pcpi_*   : valid/insn/rs1..3 in, wr/rd/wait/ready out (bridge view)
//  w_din_*  : valid/insn/rs1..3 out, ready/decoded in
//  w_dout_* : valid/rd in, ready out
interface rvb_pcpi_bridge_if #(parameter int XLEN = 32);
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic [XLEN-1:0] pcpi_rs3;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;

  logic            w_din_valid;
  logic            w_din_ready;
  logic            w_din_decoded;
  logic [31:0]     w_din_insn;
  logic [XLEN-1:0] w_din_rs1;
  logic [XLEN-1:0] w_din_rs2;
  logic [XLEN-1:0] w_din_rs3;
  logic            w_dout_valid;
  logic            w_dout_ready;
  logic [XLEN-1:0] w_dout_rd;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output w_din_valid, w_din_insn, w_din_rs1, w_din_rs2, w_din_rs3,
    input  w_din_ready, w_din_decoded,
    input  w_dout_valid, w_dout_rd,
    output w_dout_ready
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  w_din_valid, w_din_insn, w_din_rs1, w_din_rs2, w_din_rs3,
    output w_din_ready, w_din_decoded,
    output w_dout_valid, w_dout_rd,
    input  w_dout_ready
  );
endinterface

// File: rtl/rvb_pcpi_wdog.sv
// Watchdog for the bridge's WAIT state: saturating cycle counter plus a
// sticky expiry flag.
//  clk, reset : clock, synchronous active-high reset (clears counter and flag)
//  clr        : restart the count (new operation issued)
//  run        : count this cycle (bridge waiting on the worker)
//  expired    : sticky, set on the cycle the count reaches TIMEOUT
// TIMEOUT = 0 disables the flag entirely.
module rvb_pcpi_wdog
  import rvb_pcpi_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int W = wdog_w(TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && cnt != LIMIT) begin
      cnt <= cnt + W'(1);
      // Flag lands on the same edge the count reaches LIMIT.
      if (TIMEOUT != 0 && cnt == LIMIT - W'(1))
        expired <= 1'b1;
    end
  end

endmodule

// File: rtl/rvb_pcpi_bridge.sv
// PCPI-to-worker bridge. Claims PCPI instructions the worker decodes, issues
// them over the worker's din handshake, returns the worker's dout result as a
// one-cycle pcpi_ready/pcpi_wr strobe, and drains results of operations the
// core abandoned. At most one operation is ever outstanding in the worker.
//  clk, reset   : clock, synchronous active-high reset (aborts any op)
//  bus          : PCPI + worker ports (slave view)
//  stat_timeout : sticky, WAIT lasted TIMEOUT cycles at some point
//  stat_ops     : delivered-result counter, wraps
// Parameters: XLEN operand width, OUT_REG registers the result (+1 cycle),
// TIMEOUT watchdog limit (0 = off), CNT_W counter width.
module rvb_pcpi_bridge
  import rvb_pcpi_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int OUT_REG = 1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  rvb_pcpi_bridge_if.slave bus,
  output logic             stat_timeout,
  output logic [CNT_W-1:0] stat_ops
);

  bridge_state_e   st, nxt;
  logic [XLEN-1:0] rd_q;

  logic            din_v, dout_r, p_wait, p_rdy;
  logic [XLEN-1:0] p_rd;
  logic            issue, rd_ld, ops_inc;

  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt     = st;
    din_v   = 1'b0;
    dout_r  = 1'b0;
    p_wait  = 1'b0;
    p_rdy   = 1'b0;
    p_rd    = '0;
    issue   = 1'b0;
    rd_ld   = 1'b0;
    ops_inc = 1'b0;
    case (st)
      S_IDLE: begin
        // Undecoded instructions are never claimed so the core can trap.
        din_v  = bus.pcpi_valid & bus.w_din_decoded;
        p_wait = din_v;
        if (din_v && bus.w_din_ready) begin
          issue = 1'b1;
          nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        dout_r = 1'b1;
        p_wait = bus.pcpi_valid;
        if (bus.pcpi_valid) begin
          if (bus.w_dout_valid) begin
            if (OUT_REG != 0) begin
              rd_ld = 1'b1;
              nxt   = S_RESP;
            end else begin
              p_rdy   = 1'b1;
              p_rd    = bus.w_dout_rd;
              ops_inc = 1'b1;
              nxt     = S_HOLD;
            end
          end
        end else begin
          // Core abandoned the op: swallow the result now or later.
          nxt = bus.w_dout_valid ? S_HOLD : S_DRAIN;
        end
      end
      S_RESP: begin
        // Delivered regardless of pcpi_valid; a stale ready is ignored.
        p_rdy   = 1'b1;
        p_rd    = rd_q;
        ops_inc = 1'b1;
        nxt     = S_HOLD;
      end
      S_HOLD: begin
        // Core still shows the completed insn this cycle; don't re-issue it.
        nxt = S_IDLE;
      end
      S_DRAIN: begin
        dout_r = 1'b1;
        p_wait = bus.pcpi_valid & bus.w_din_decoded;
        if (bus.w_dout_valid) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_q <= '0;
    else if (rd_ld) rd_q <= bus.w_dout_rd;
  end

  always_ff @(posedge clk) begin
    if (reset)        stat_ops <= '0;
    else if (ops_inc) stat_ops <= stat_ops + CNT_W'(1);
  end

  rvb_pcpi_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (issue),
    .run     (st == S_WAIT),
    .expired (stat_timeout)
  );

  assign bus.w_din_valid  = din_v;
  assign bus.w_dout_ready = dout_r;
  assign bus.pcpi_wait    = p_wait;
  assign bus.pcpi_ready   = p_rdy;
  assign bus.pcpi_wr      = p_rdy;
  assign bus.pcpi_rd      = p_rd;

  assign bus.w_din_insn = bus.pcpi_insn;
  assign bus.w_din_rs1  = bus.pcpi_rs1;
  assign bus.w_din_rs2  = bus.pcpi_rs2;
  assign bus.w_din_rs3  = bus.pcpi_rs3;

endmodule

// File: tb/tb_rvb_pcpi_bridge.sv
// Three bridges share one stimulus: A (XLEN 32, registered, TIMEOUT 8),
// B (XLEN 32, unregistered, watchdog off), C (XLEN 64, registered, TIMEOUT 64).
module tb_rvb_pcpi_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        v = 0, dec = 0, dr = 0, dov = 0;
  logic [63:0] rd = '0;
  logic [31:0] insn = 32'h0A50_F00B;
  logic [63:0] rs1 = 64'h1000_0000_0000_0001;
  logic [63:0] rs2 = 64'h2000_0000_0000_0002;
  logic [63:0] rs3 = 64'h3000_0000_0000_0003;

  rvb_pcpi_bridge_if #(.XLEN(32)) ifa ();
  rvb_pcpi_bridge_if #(.XLEN(32)) ifb ();
  rvb_pcpi_bridge_if #(.XLEN(64)) ifc ();

  assign ifa.pcpi_valid = v;   assign ifb.pcpi_valid = v;   assign ifc.pcpi_valid = v;
  assign ifa.pcpi_insn = insn; assign ifb.pcpi_insn = insn; assign ifc.pcpi_insn = insn;
  assign ifa.pcpi_rs1 = rs1[31:0]; assign ifb.pcpi_rs1 = rs1[31:0]; assign ifc.pcpi_rs1 = rs1;
  assign ifa.pcpi_rs2 = rs2[31:0]; assign ifb.pcpi_rs2 = rs2[31:0]; assign ifc.pcpi_rs2 = rs2;
  assign ifa.pcpi_rs3 = rs3[31:0]; assign ifb.pcpi_rs3 = rs3[31:0]; assign ifc.pcpi_rs3 = rs3;
  assign ifa.w_din_ready = dr;    assign ifb.w_din_ready = dr;    assign ifc.w_din_ready = dr;
  assign ifa.w_din_decoded = dec; assign ifb.w_din_decoded = dec; assign ifc.w_din_decoded = dec;
  assign ifa.w_dout_valid = dov;  assign ifb.w_dout_valid = dov;  assign ifc.w_dout_valid = dov;
  assign ifa.w_dout_rd = rd[31:0]; assign ifb.w_dout_rd = rd[31:0]; assign ifc.w_dout_rd = rd;

  logic        to_a, to_b, to_c;
  logic [31:0] ops_a, ops_b, ops_c;

  rvb_pcpi_bridge #(.XLEN(32), .OUT_REG(1), .TIMEOUT(8), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .stat_timeout(to_a), .stat_ops(ops_a));
  rvb_pcpi_bridge #(.XLEN(32), .OUT_REG(0), .TIMEOUT(0), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .stat_timeout(to_b), .stat_ops(ops_b));
  rvb_pcpi_bridge #(.XLEN(64), .OUT_REG(1), .TIMEOUT(64), .CNT_W(32)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc), .stat_timeout(to_c), .stat_ops(ops_c));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive just after the edge, return mid-cycle to sample.
  task automatic drv(input logic vv, dd, rr, oo, input logic [63:0] d);
    @(posedge clk);
    #1;
    v = vv; dec = dd; dr = rr; dov = oo; rd = d;
    #4;
  endtask

  // Per-cycle inputs and expected outputs: dv=w_din_valid, dor=w_dout_ready
  // (common to A and B), then wait/ready/rd for A and for B.
  typedef struct {
    logic        v, dec, dr, dov;
    logic [63:0] rd;
    logic        dv, dor;
    logic        aw, ar;
    logic [31:0] ard;
    logic        bw, br;
    logic [31:0] brd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vv, dd, rr, oo, input logic [63:0] d,
                     input logic dv, dor, aw, ar, input logic [31:0] ard,
                     input logic bw, br, input logic [31:0] brd);
    vec_t t;
    t.v = vv; t.dec = dd; t.dr = rr; t.dov = oo; t.rd = d;
    t.dv = dv; t.dor = dor; t.aw = aw; t.ar = ar; t.ard = ard;
    t.bw = bw; t.br = br; t.brd = brd;
    tbl.push_back(t);
  endtask

  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  initial begin
    int ea, eb;
    // ---- table ----
    // basic op, result 3 cycles after issue
    add(1,1,1,0, 0,  1,0, 1,0,0,  1,0,0);
    add(1,1,1,0, 0,  0,1, 1,0,0,  1,0,0);
    add(1,1,1,0, 0,  0,1, 1,0,0,  1,0,0);
    add(1,1,1,1, DB, 0,1, 1,0,0,  1,1,DB);
    add(1,1,1,0, DB, 0,0, 0,1,DB, 0,0,0);
    add(0,1,1,0, DB, 0,0, 0,0,0,  0,0,0);
    add(0,1,1,0, DB, 0,0, 0,0,0,  0,0,0);
    // undecoded instruction held 10 cycles
    for (int i = 0; i < 10; i++) add(1,0,1,0, 0, 0,0, 0,0,0, 0,0,0);
    // worker not ready first, then result in first WAIT cycle
    add(1,1,0,0, 0, 1,0, 1,0,0, 1,0,0);
    add(1,1,1,0, 0, 1,0, 1,0,0, 1,0,0);
    add(1,1,1,1, 5, 0,1, 1,0,0, 1,1,5);
    add(1,1,1,0, 5, 0,0, 0,1,5, 0,0,0);
    add(0,1,1,0, 5, 0,0, 0,0,0, 0,0,0);
    // abandon -> DRAIN, new insn stalls, issues after drain
    add(1,1,1,0, 0,     1,0, 1,0,0,     1,0,0);
    add(1,1,1,0, 0,     0,1, 1,0,0,     1,0,0);
    add(0,1,1,0, 0,     0,1, 0,0,0,     0,0,0);
    add(0,1,1,0, 0,     0,1, 0,0,0,     0,0,0);
    add(1,1,1,0, 0,     0,1, 1,0,0,     1,0,0);
    add(1,1,1,0, 0,     0,1, 1,0,0,     1,0,0);
    add(1,1,1,1, 'hBAD, 0,1, 1,0,0,     1,0,0);
    add(1,1,1,0, 0,     1,0, 1,0,0,     1,0,0);
    add(1,1,1,1, 'h11,  0,1, 1,0,0,     1,1,'h11);
    add(1,1,1,0, 'h11,  0,0, 0,1,'h11,  0,0,0);
    add(0,1,1,0, 0,     0,0, 0,0,0,     0,0,0);
    // abandon on the same cycle the result arrives -> HOLD, no delivery
    add(1,1,1,0, 0,    1,0, 1,0,0, 1,0,0);
    add(0,1,1,1, 'h77, 0,1, 0,0,0, 0,0,0);
    add(1,1,1,0, 'h77, 0,0, 0,0,0, 0,0,0);
    add(0,1,1,0, 0,    0,0, 0,0,0, 0,0,0);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #4;
    chk("reset_a", {ifa.w_din_valid, ifa.w_dout_ready, ifa.pcpi_wait, ifa.pcpi_ready, ifa.pcpi_wr, ifa.pcpi_rd, ops_a, to_a}, '0);
    chk("reset_b", {ifb.w_din_valid, ifb.w_dout_ready, ifb.pcpi_wait, ifb.pcpi_ready, ifb.pcpi_wr, ifb.pcpi_rd, ops_b, to_b}, '0);
    chk("reset_c", {ifc.w_din_valid, ifc.w_dout_ready, ifc.pcpi_wait, ifc.pcpi_ready, ifc.pcpi_wr, ifc.pcpi_rd, ops_c, to_c}, '0);
    chk("insn_pass", ifa.w_din_insn, insn);
    chk("rs_pass_c", {ifc.w_din_rs1, ifc.w_din_rs2, ifc.w_din_rs3}, {rs1, rs2, rs3});
    @(posedge clk);
    #1 reset = 1'b0;

    // ---- table run ----
    ea = 0; eb = 0;
    foreach (tbl[i]) begin
      drv(tbl[i].v, tbl[i].dec, tbl[i].dr, tbl[i].dov, tbl[i].rd);
      chk($sformatf("vec%0d_a", i),
          {ifa.w_din_valid, ifa.w_dout_ready, ifa.pcpi_wait, ifa.pcpi_ready, ifa.pcpi_wr, ifa.pcpi_rd, ops_a},
          {tbl[i].dv, tbl[i].dor, tbl[i].aw, tbl[i].ar, tbl[i].ar, tbl[i].ard, 32'(ea)});
      chk($sformatf("vec%0d_b", i),
          {ifb.w_din_valid, ifb.w_dout_ready, ifb.pcpi_wait, ifb.pcpi_ready, ifb.pcpi_wr, ifb.pcpi_rd, ops_b},
          {tbl[i].dv, tbl[i].dor, tbl[i].bw, tbl[i].br, tbl[i].br, tbl[i].brd, 32'(eb)});
      ea += int'(tbl[i].ar);
      eb += int'(tbl[i].br);
    end
    chk("ops_after_tbl", {ops_a, ops_b}, {32'd3, 32'd3});
    chk("no_timeout_yet", {to_a, to_b, to_c}, 3'b000);

    // ---- watchdog: worker answers after 12 WAIT cycles ----
    drv(1,1,1,0, 0);
    for (int k = 0; k < 12; k++) begin
      drv(1,1,1,0, 0);
      chk($sformatf("wdog_k%0d", k), {to_a, to_b, to_c}, {(k >= 8) ? 1'b1 : 1'b0, 2'b00});
    end
    drv(1,1,1,1, 64'h1111_2222_CAFE_F00D);
    chk("wdog_b_rdy", {ifb.pcpi_ready, ifb.pcpi_rd, ifa.pcpi_ready, to_a}, {1'b1, 32'hCAFE_F00D, 1'b0, 1'b1});
    drv(1,1,1,0, 64'h1111_2222_CAFE_F00D);
    chk("wdog_a_rdy", {ifa.pcpi_ready, ifa.pcpi_rd}, {1'b1, 32'hCAFE_F00D});
    chk("wdog_c_rdy", {ifc.pcpi_ready, ifc.pcpi_rd}, {1'b1, 64'h1111_2222_CAFE_F00D});
    for (int k = 0; k < 3; k++) begin
      drv(0,1,1,0, 0);
      chk($sformatf("wdog_sticky%0d", k), {to_a, to_c}, 2'b10);
    end
    chk("ops_after_wdog", {ops_a, ops_b}, {32'd4, 32'd4});

    // ---- reset in WAIT, then a fresh 64-bit op ----
    drv(1,1,1,0, 0);
    drv(1,1,1,0, 0);
    chk("c_in_wait", {ifc.pcpi_wait, ifc.w_dout_ready}, 2'b11);
    @(posedge clk);
    #1 reset = 1'b1; v = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #4;
    chk("midreset_c", {ifc.w_din_valid, ifc.w_dout_ready, ifc.pcpi_wait, ifc.pcpi_ready, ifc.pcpi_wr, ifc.pcpi_rd, ops_c, to_c}, '0);
    chk("midreset_a", {ifa.pcpi_wait, ifa.w_dout_ready, ops_a, to_a}, '0);
    drv(1,1,1,0, 0);
    chk("c_issue", {ifc.w_din_valid, ifc.pcpi_wait}, 2'b11);
    drv(1,1,1,0, 0);
    drv(1,1,1,1, 64'h0123_4567_89AB_CDEF);
    chk("c_no_rdy_yet", ifc.pcpi_ready, 1'b0);
    drv(1,1,1,0, 64'h0123_4567_89AB_CDEF);
    chk("c_rdy64", {ifc.pcpi_ready, ifc.pcpi_wr, ifc.pcpi_rd}, {2'b11, 64'h0123_4567_89AB_CDEF});
    chk("a_rdy_low", {ifa.pcpi_ready, ifa.pcpi_rd}, {1'b1, 32'h89AB_CDEF});
    drv(0,1,1,0, 0);
    chk("c_after", {ifc.pcpi_ready, ifc.pcpi_rd, ops_c}, {1'b0, 64'h0, 32'd1});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
